// File: rtl/arb_pkg.sv
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared types and constants for operand_bus_arbiter:
//                arbiter state encoding, burst/statistics counter widths
//                and a saturating-increment helper for the statistics counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } arb_state_e;

    localparam int BURST_CNT_W = 8;
    localparam int STATS_W     = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_grant_fsm.sv
// ============================================================================
//  Module      : rr_grant_fsm
//  Description : Round-robin grant FSM with a per-owner burst limit.
//                Holds state, burst_cnt and last_winner; the grant is
//                registered so the datapath select never glitches.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                req0/1_valid    - requester word pending
//                xfer            - a transfer completes this cycle
//                owned           - some requester owns the bus
//                grant, ctl      - current owner (0/1), mux select
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_grant_fsm
    import arb_pkg::*;
#(
    parameter int BURST_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0_valid,
    input  logic req1_valid,
    input  logic xfer,
    output logic owned,
    output logic grant,
    output logic ctl
);

    localparam logic [BURST_CNT_W:0]   C_BURST_MAX  = (BURST_CNT_W+1)'(BURST_MAX);
    localparam logic [BURST_CNT_W-1:0] C_BURST_LAST = BURST_CNT_W'(BURST_MAX - 1);

    arb_state_e             state_q, state_d;
    logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic                   last_winner_q, last_winner_d;

    logic                   w_own_v;
    logic                   w_oth_v;
    arb_state_e             w_other;
    logic [BURST_CNT_W:0]   w_cnt_inc;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            burst_cnt_q   <= '0;
            last_winner_q <= 1'b1;   // req0 wins the first tie
        end else begin
            state_q       <= state_d;
            burst_cnt_q   <= burst_cnt_d;
            last_winner_q <= last_winner_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d       = state_q;
        burst_cnt_d   = burst_cnt_q;
        last_winner_d = last_winner_q;
        w_own_v       = (state_q == OWN1) ? req1_valid : req0_valid;
        w_oth_v       = (state_q == OWN1) ? req0_valid : req1_valid;
        w_other       = (state_q == OWN1) ? OWN0 : OWN1;
        w_cnt_inc     = {1'b0, burst_cnt_q} + 1'b1;

        case (state_q)
            IDLE: begin
                burst_cnt_d = '0;
                if (req0_valid && req1_valid) begin
                    state_d = last_winner_q ? OWN0 : OWN1;
                end else if (req0_valid) begin
                    state_d = OWN0;
                end else if (req1_valid) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (xfer) begin
                    last_winner_d = (state_q == OWN1);
                end
                if (xfer && (w_cnt_inc == C_BURST_MAX) && w_oth_v) begin
                    state_d     = w_other;
                    burst_cnt_d = '0;
                end else if (!w_own_v && w_oth_v) begin
                    state_d     = w_other;
                    burst_cnt_d = '0;
                end else if (!w_own_v) begin
                    state_d     = IDLE;
                    burst_cnt_d = '0;
                end else if (xfer) begin
                    // Saturate so a lone owner keeps streaming; the next
                    // transfer after the other side raises valid hands over.
                    burst_cnt_d = (w_cnt_inc >= C_BURST_MAX) ? C_BURST_LAST
                                                             : w_cnt_inc[BURST_CNT_W-1:0];
                end
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    // Outputs (decoded from registered state only)
    always_comb begin
        owned = (state_q == OWN0) || (state_q == OWN1);
        grant = (state_q == OWN1);
        ctl   = grant;
    end

endmodule

`default_nettype wire

// File: rtl/operand_bus_arbiter.sv
// ============================================================================
//  Module      : operand_bus_arbiter
//  Description : Arbitrates two 32-bit operand requesters onto one datapath.
//                Registered round-robin grant with burst limit drives the
//                2:1 select; selected word lands in a one-entry output stage
//                with valid/ready handshake.
//  Ports       : clk, rst_n                  - clock, async active-low reset
//                reqN_valid/data/ready       - requester N handshake
//                ctl                         - mux select (registered grant)
//                out_valid/data/src/ready    - output handshake
//                grant_cnt0/1                - per-requester transfer counts
//                                              (only with ARB_STATS_EN)
//  Config      : `define ARB_STATS_EN adds saturating 16-bit grant counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_bus_arbiter
    import arb_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int BURST_MAX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    input  logic [WIDTH-1:0]   req0_data,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [WIDTH-1:0]   req1_data,
    output logic               req1_ready,
    output logic               ctl,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_src,
    input  logic               out_ready
`ifdef ARB_STATS_EN
    ,
    output logic [STATS_W-1:0] grant_cnt0,
    output logic [STATS_W-1:0] grant_cnt1
`endif
);

    logic             w_owned;
    logic             w_grant;
    logic             w_out_free;
    logic             w_xfer0;
    logic             w_xfer1;
    logic             w_xfer;
    logic [WIDTH-1:0] w_sel_data;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_src_q,   out_src_d;

    rr_grant_fsm #(
        .BURST_MAX (BURST_MAX)
    ) u_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .xfer       (w_xfer),
        .owned      (w_owned),
        .grant      (w_grant),
        .ctl        (ctl)
    );

    // Ready depends only on registered state and out_ready, never on valid.
    always_comb begin
        w_out_free = !out_valid_q || out_ready;
        req0_ready = w_owned && !w_grant && w_out_free;
        req1_ready = w_owned &&  w_grant && w_out_free;
        w_xfer0    = req0_valid && req0_ready;
        w_xfer1    = req1_valid && req1_ready;
        w_xfer     = w_xfer0 || w_xfer1;
        w_sel_data = ctl ? req1_data : req0_data;
    end

    // Output stage: reload on transfer (even while draining), else drain.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (w_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = w_sel_data;
            out_src_d   = ctl;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

`ifdef ARB_STATS_EN
    logic [STATS_W-1:0] grant_cnt0_q, grant_cnt0_d;
    logic [STATS_W-1:0] grant_cnt1_q, grant_cnt1_d;

    always_comb begin
        grant_cnt0_d = w_xfer0 ? sat_inc(grant_cnt0_q) : grant_cnt0_q;
        grant_cnt1_d = w_xfer1 ? sat_inc(grant_cnt1_q) : grant_cnt1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
        end else begin
            grant_cnt0_q <= grant_cnt0_d;
            grant_cnt1_q <= grant_cnt1_d;
        end
    end

    assign grant_cnt0 = grant_cnt0_q;
    assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule

`default_nettype wire
